uart_time_cmd_rx: RTL and testbench

- Receive side of the host UART time link: accepts ASCII time-set commands of the form "THH:MM:SS" followed by CR or LF.
- Decodes each command into packed BCD and checks the fields against valid time ranges.
- Issues a one-cycle strobe so the RTC write path can load the new time.
- Is the inverse of the ASCII time-report transmitter on the same serial line: 8N1 framing, LSB first, idle high.

---
 rtl/uart_time_cmd_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_time_cmd_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_cmd_rx.sv
// rtl/uart_time_cmd_rx.sv - UART receiver and "THH:MM:SS" time-set command parser
module uart_time_cmd_rx #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_rx,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [23:0] time_set,
  output logic        time_set_valid,
  output logic        cmd_err,
  output logic        frame_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(HALF_DIV - 1);
  // Counter clears in the strobe cycle and cmd_err is registered, so firing
  // two counts early lands the error exactly TIMEOUT_CYCLES after the strobe.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 2);

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [3:0] {
    P_IDLE, P_H1, P_H0, P_C1, P_M1, P_M0, P_C2, P_S1, P_S0, P_END
  } p_state_t;

  rx_state_t r_rstate, w_rnext;
  p_state_t  r_pstate, w_pnext;

  logic          r_sync1, r_sync2, r_rx_prev;
  logic          w_rx_s, w_fall;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          w_load_half, w_load_full, w_cnt_dec, w_shift_en;
  logic          w_stop_ok, w_stop_bad;

  logic [23:0]   r_stage, w_stage_next;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout, w_is_digit, w_bad, w_accept, w_perr;
  logic [3:0]    w_nib;

  // Two-flop synchronizer plus a delayed copy for start-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= uart_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx_s;

  // Receiver state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rstate <= R_IDLE;
    else       r_rstate <= w_rnext;
  end

  // Receiver next-state and sampling controls
  always_comb begin
    w_rnext     = r_rstate;
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_cnt_dec   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_fall) begin
          w_load_half = 1'b1;
          w_rnext     = R_START;
        end
      end
      R_START: begin
        if (r_baud_cnt == '0) begin
          if (w_rx_s) begin
            w_rnext = R_IDLE;
          end else begin
            w_load_full = 1'b1;
            w_rnext     = R_DATA;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      R_DATA: begin
        if (r_baud_cnt == '0) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (r_bit_cnt == 3'd7) w_rnext = R_STOP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      R_STOP: begin
        if (r_baud_cnt == '0) begin
          w_stop_ok  = w_rx_s;
          w_stop_bad = ~w_rx_s;
          w_rnext    = R_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  // Receiver datapath: baud/bit counters, shift register, byte strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= w_stop_ok;
      frame_err     <= w_stop_bad;
      if (w_load_half)      r_baud_cnt <= HALF_LOAD;
      else if (w_load_full) r_baud_cnt <= FULL_LOAD;
      else if (w_cnt_dec)   r_baud_cnt <= r_baud_cnt - BW'(1);
      if (w_load_half)      r_bit_cnt  <= '0;
      else if (w_shift_en)  r_bit_cnt  <= r_bit_cnt + 3'd1;
      if (w_shift_en)       r_shift    <= {w_rx_s, r_shift[7:1]};
      if (w_stop_ok)        rx_byte    <= r_shift;
    end
  end

  assign w_is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign w_nib      = rx_byte[3:0];
  assign w_timeout  = (r_pstate != P_IDLE) && (r_to_cnt == TO_LAST);

  // Parser state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pstate <= P_IDLE;
    else       r_pstate <= w_pnext;
  end

  // Parser next-state, staging updates, accept/error decisions
  always_comb begin
    w_pnext      = r_pstate;
    w_stage_next = r_stage;
    w_bad        = 1'b0;
    w_accept     = 1'b0;
    w_perr       = 1'b0;
    if (frame_err) begin
      w_pnext = P_IDLE;
    end else if (rx_byte_valid) begin
      case (r_pstate)
        P_IDLE: if (rx_byte == CH_T) w_pnext = P_H1;
        P_H1: begin
          if (w_is_digit && (w_nib <= 4'd2)) begin
            w_stage_next[23:20] = w_nib;
            w_pnext             = P_H0;
          end else w_bad = 1'b1;
        end
        P_H0: begin
          if (w_is_digit) begin
            w_stage_next[19:16] = w_nib;
            w_pnext             = P_C1;
          end else w_bad = 1'b1;
        end
        P_C1: if (rx_byte == CH_COLON) w_pnext = P_M1; else w_bad = 1'b1;
        P_M1: begin
          if (w_is_digit && (w_nib <= 4'd5)) begin
            w_stage_next[15:12] = w_nib;
            w_pnext             = P_M0;
          end else w_bad = 1'b1;
        end
        P_M0: begin
          if (w_is_digit) begin
            w_stage_next[11:8] = w_nib;
            w_pnext            = P_C2;
          end else w_bad = 1'b1;
        end
        P_C2: if (rx_byte == CH_COLON) w_pnext = P_S1; else w_bad = 1'b1;
        P_S1: begin
          if (w_is_digit && (w_nib <= 4'd5)) begin
            w_stage_next[7:4] = w_nib;
            w_pnext           = P_S0;
          end else w_bad = 1'b1;
        end
        P_S0: begin
          if (w_is_digit) begin
            w_stage_next[3:0] = w_nib;
            w_pnext           = P_END;
          end else w_bad = 1'b1;
        end
        P_END: begin
          if ((rx_byte == CH_CR) || (rx_byte == CH_LF)) begin
            w_pnext = P_IDLE;
            if (r_stage[23:16] <= 8'h23) w_accept = 1'b1;
            else                         w_perr   = 1'b1;
          end else w_bad = 1'b1;
        end
        default: w_pnext = P_IDLE;
      endcase
      if (w_bad) begin
        w_perr  = 1'b1;
        w_pnext = (rx_byte == CH_T) ? P_H1 : P_IDLE;
      end
    end else if (w_timeout) begin
      w_perr  = 1'b1;
      w_pnext = P_IDLE;
    end
  end

  // Parser datapath: staging, committed time, strobes, inter-byte timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stage        <= '0;
      time_set       <= '0;
      time_set_valid <= 1'b0;
      cmd_err        <= 1'b0;
      r_to_cnt       <= '0;
    end else begin
      r_stage        <= w_stage_next;
      time_set_valid <= w_accept;
      cmd_err        <= w_perr;
      if (w_accept) time_set <= r_stage;
      if (rx_byte_valid || (r_pstate == P_IDLE)) r_to_cnt <= '0;
      else                                       r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_time_cmd_rx.sv
// tb/tb_uart_time_cmd_rx.sv - scoreboard bench for uart_time_cmd_rx
module tb_uart_time_cmd_rx;
  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int TIMEOUT  = 2000;
  localparam int BD       = CLK_FREQ / BAUD;
  localparam int LAT      = (BD * 19) / 2 + 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [23:0] time_set;
  logic        time_set_valid;
  logic        cmd_err;
  logic        frame_err;

  uart_time_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .time_set(time_set), .time_set_valid(time_set_valid),
    .cmd_err(cmd_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rbv_cnt = 0, tsv_cnt = 0, ce_cnt = 0, fe_cnt = 0;
  int rbv_cyc = 0, tsv_cyc = 0, ce_cyc = 0, term_cyc = 0;
  logic [7:0]  exp_bytes[$];
  logic [23:0] exp_ts[$];

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: pop expectations as the DUT strobes
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_byte_valid) begin
        rbv_cnt++;
        rbv_cyc = cyc;
        total++;
        if (exp_bytes.size() == 0) begin
          bad++;
          $display("FAIL rx_byte_unexpected got=%h exp=none", rx_byte);
        end else begin
          automatic logic [7:0] e = exp_bytes.pop_front();
          if (rx_byte !== e) begin
            bad++;
            $display("FAIL rx_byte got=%h exp=%h", rx_byte, e);
          end
        end
      end
      if (time_set_valid) begin
        tsv_cnt++;
        tsv_cyc = cyc;
        total++;
        if (exp_ts.size() == 0) begin
          bad++;
          $display("FAIL time_set_unexpected got=%h exp=none", time_set);
        end else begin
          automatic logic [23:0] t = exp_ts.pop_front();
          if (time_set !== t) begin
            bad++;
            $display("FAIL time_set got=%h exp=%h", time_set, t);
          end
        end
      end
      if (cmd_err) begin
        ce_cnt++;
        ce_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
      if (time_set_valid || cmd_err) begin
        total++;
        if (time_set_valid && cmd_err) begin
          bad++;
          $display("FAIL strobe_exclusive got=both exp=one");
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (b == 8'h0D || b == 8'h0A) term_cyc = cyc;
    if (stop) exp_bytes.push_back(b);
    uart_rx = 1'b0;
    idle(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(BD);
    end
    uart_rx = stop;
    idle(BD);
    uart_rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    total++;
    if ({rx_byte, rx_byte_valid, time_set, time_set_valid, cmd_err, frame_err} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rx_byte, rx_byte_valid, time_set, time_set_valid, cmd_err, frame_err});
    end
    rstn = 1'b1;
    idle(2 * BD);
  endtask

  task automatic test_basic();
    int b_rbv = rbv_cnt, b_tsv = tsv_cnt, b_ce = ce_cnt, b_fe = fe_cnt;
    int lat;
    exp_ts.push_back(24'h123456);
    send_str("T12:34:56");
    send_byte(8'h0D, 1'b1);
    idle(20);
    total++;
    if (rbv_cnt - b_rbv !== 10 || tsv_cnt - b_tsv !== 1 || ce_cnt - b_ce !== 0 || fe_cnt - b_fe !== 0) begin
      bad++;
      $display("FAIL basic_counts got rbv=%0d tsv=%0d ce=%0d fe=%0d exp 10 1 0 0",
               rbv_cnt - b_rbv, tsv_cnt - b_tsv, ce_cnt - b_ce, fe_cnt - b_fe);
    end
    total++;
    if (time_set !== 24'h123456) begin
      bad++;
      $display("FAIL basic_time_set got=%h exp=123456", time_set);
    end
    lat = tsv_cyc - (term_cyc + 1);
    total++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  task automatic test_range();
    int b_tsv = tsv_cnt, b_ce = ce_cnt;
    send_str("T24:00:00");
    send_byte(8'h0A, 1'b1);
    idle(20);
    total++;
    if (ce_cnt - b_ce !== 1 || tsv_cnt - b_tsv !== 0 || ce_cyc !== rbv_cyc + 1) begin
      bad++;
      $display("FAIL range_hour got ce=%0d tsv=%0d dly=%0d exp 1 0 1",
               ce_cnt - b_ce, tsv_cnt - b_tsv, ce_cyc - rbv_cyc);
    end
    total++;
    if (time_set !== 24'h123456) begin
      bad++;
      $display("FAIL range_hold got=%h exp=123456", time_set);
    end
    b_ce = ce_cnt;
    send_str("T12:6");
    idle(20);
    total++;
    if (ce_cnt - b_ce !== 1 || ce_cyc !== rbv_cyc + 1) begin
      bad++;
      $display("FAIL range_min_tens got ce=%0d dly=%0d exp 1 1", ce_cnt - b_ce, ce_cyc - rbv_cyc);
    end
    b_ce = ce_cnt;
    send_str("0:00:00");
    send_byte(8'h0D, 1'b1);
    idle(TIMEOUT + 100);
    total++;
    if (ce_cnt - b_ce !== 0 || tsv_cnt - b_tsv !== 0) begin
      bad++;
      $display("FAIL range_back_idle got ce=%0d tsv=%0d exp 0 0", ce_cnt - b_ce, tsv_cnt - b_tsv);
    end
  endtask

  task automatic test_back_to_back();
    int b_tsv = tsv_cnt, b_ce = ce_cnt;
    exp_ts.push_back(24'h235959);
    exp_ts.push_back(24'h000000);
    send_str("T23:59:59");
    send_byte(8'h0A, 1'b1);
    send_str("T00:00:00");
    send_byte(8'h0D, 1'b1);
    idle(20);
    total++;
    if (tsv_cnt - b_tsv !== 2 || ce_cnt - b_ce !== 0 || time_set !== 24'h000000) begin
      bad++;
      $display("FAIL b2b got tsv=%0d ce=%0d ts=%h exp 2 0 000000", tsv_cnt - b_tsv, ce_cnt - b_ce, time_set);
    end
  endtask

  task automatic test_resync();
    int b_tsv = tsv_cnt, b_ce = ce_cnt;
    exp_ts.push_back(24'h081530);
    send_str("T12:3T08:15:30");
    send_byte(8'h0D, 1'b1);
    idle(20);
    total++;
    if (tsv_cnt - b_tsv !== 1 || ce_cnt - b_ce !== 1 || time_set !== 24'h081530) begin
      bad++;
      $display("FAIL resync got tsv=%0d ce=%0d ts=%h exp 1 1 081530", tsv_cnt - b_tsv, ce_cnt - b_ce, time_set);
    end
  endtask

  task automatic test_timeout();
    int b_ce = ce_cnt, b_tsv = tsv_cnt, colon_cyc;
    send_str("T12:");
    colon_cyc = rbv_cyc;
    idle(TIMEOUT + TIMEOUT / 2);
    total++;
    if (ce_cnt - b_ce !== 1 || ce_cyc - colon_cyc < TIMEOUT - 1 || ce_cyc - colon_cyc > TIMEOUT + 1) begin
      bad++;
      $display("FAIL timeout got ce=%0d at=%0d exp 1 at %0d", ce_cnt - b_ce, ce_cyc - colon_cyc, TIMEOUT);
    end
    exp_ts.push_back(24'h010203);
    send_str("T01:02:03");
    send_byte(8'h0D, 1'b1);
    idle(20);
    total++;
    if (tsv_cnt - b_tsv !== 1 || time_set !== 24'h010203) begin
      bad++;
      $display("FAIL timeout_recover got tsv=%0d ts=%h exp 1 010203", tsv_cnt - b_tsv, time_set);
    end
  endtask

  task automatic test_frame();
    int b_ce = ce_cnt, b_fe = fe_cnt, b_rbv;
    send_str("T12:");
    send_byte(8'h33, 1'b0);
    idle(TIMEOUT + 200);
    total++;
    if (fe_cnt - b_fe !== 1 || ce_cnt - b_ce !== 0) begin
      bad++;
      $display("FAIL frame_err got fe=%0d ce=%0d exp 1 0", fe_cnt - b_fe, ce_cnt - b_ce);
    end
    b_rbv = rbv_cnt;
    b_fe = fe_cnt;
    uart_rx = 1'b0;
    idle(BD / 2 - 3);
    uart_rx = 1'b1;
    idle(3 * BD);
    total++;
    if (rbv_cnt - b_rbv !== 0 || fe_cnt - b_fe !== 0) begin
      bad++;
      $display("FAIL glitch got rbv=%0d fe=%0d exp 0 0", rbv_cnt - b_rbv, fe_cnt - b_fe);
    end
  endtask

  task automatic test_reset_mid();
    int b_tsv;
    send_str("T1");
    uart_rx = 1'b0;
    idle(BD * 3);
    rstn = 1'b0;
    #1;
    total++;
    if ({rx_byte, rx_byte_valid, time_set, time_set_valid, cmd_err, frame_err} !== 36'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h exp=0",
               {rx_byte, rx_byte_valid, time_set, time_set_valid, cmd_err, frame_err});
    end
    uart_rx = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(2 * BD);
    b_tsv = tsv_cnt;
    exp_ts.push_back(24'h070809);
    send_str("T07:08:09");
    send_byte(8'h0D, 1'b1);
    idle(20);
    total++;
    if (tsv_cnt - b_tsv !== 1 || time_set !== 24'h070809) begin
      bad++;
      $display("FAIL reset_mid_recover got tsv=%0d ts=%h exp 1 070809", tsv_cnt - b_tsv, time_set);
    end
  endtask

  initial begin
    idle(1);
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_resync();
    test_timeout();
    test_frame();
    test_reset_mid();
    total++;
    if (exp_bytes.size() !== 0 || exp_ts.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain got bytes=%0d ts=%0d exp 0 0", exp_bytes.size(), exp_ts.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
